// File: rtl/dmem_line_responder.sv
// rtl/dmem_line_responder.sv - line-wide DMEM strobe/done responder with programmable latency
// Accepts one line request in IDLE, counts its latency in WAIT, pulses done in DONE.
module dmem_line_responder #(
    parameter int XLEN       = 32,
    parameter int CLSIZE     = 256,
    parameter int DEPTH      = 1024,
    parameter int RD_LATENCY = 4,
    parameter int WR_LATENCY = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              S_DMEM_strobe_i,
    input  logic [XLEN-1:0]   S_DMEM_addr_i,
    input  logic              S_DMEM_rw_i,
    input  logic [CLSIZE-1:0] S_DMEM_data_i,
    output logic              S_DMEM_done_o,
    output logic [CLSIZE-1:0] S_DMEM_data_o,
    output logic              busy_o
);
    localparam int OFF    = $clog2(CLSIZE / 8);
    localparam int IW     = $clog2(DEPTH);
    localparam int MAXLAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int CW     = $clog2(MAXLAT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_cnt_next;
    logic [CW-1:0]     w_lat_m1;
    logic [IW-1:0]     r_idx;
    logic              r_rw;
    logic [CLSIZE-1:0] r_wdata;
    logic [CLSIZE-1:0] r_rdata;
    logic [CLSIZE-1:0] r_mem [DEPTH];

    logic              w_accept;
    logic              w_enter_done;
    logic [IW-1:0]     w_idx_in;
    logic [IW-1:0]     w_op_idx;
    logic              w_op_rw;
    logic [CLSIZE-1:0] w_op_wdata;
    logic              w_unused;

    // Tag and offset bits are dropped, so addresses beyond DEPTH lines alias.
    assign w_idx_in = S_DMEM_addr_i[OFF +: IW];
    assign w_unused = ^{S_DMEM_addr_i[XLEN-1:OFF+IW], S_DMEM_addr_i[OFF-1:0]};
    assign w_lat_m1 = S_DMEM_rw_i ? CW'(WR_LATENCY - 1) : CW'(RD_LATENCY - 1);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (S_DMEM_strobe_i) begin
                    w_accept     = 1'b1;
                    w_cnt_next   = w_lat_m1;
                    w_state_next = (w_lat_m1 == '0) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_cnt_next = r_cnt - 1'b1;
                if (r_cnt == CW'(1)) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // A single-cycle request completes on its acceptance edge, so it uses the live inputs.
    assign w_enter_done = (w_state_next == ST_DONE) && (r_state != ST_DONE);
    assign w_op_idx     = (r_state == ST_IDLE) ? w_idx_in      : r_idx;
    assign w_op_rw      = (r_state == ST_IDLE) ? S_DMEM_rw_i   : r_rw;
    assign w_op_wdata   = (r_state == ST_IDLE) ? S_DMEM_data_i : r_wdata;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_rw    <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_idx   <= w_idx_in;
                r_rw    <= S_DMEM_rw_i;
                r_wdata <= S_DMEM_data_i;
            end
            if (w_enter_done && !w_op_rw) begin
                r_rdata <= r_mem[w_op_idx];
            end
        end
    end

    // Store has no reset; the rst_ni gate keeps a request seen during reset from committing.
    always_ff @(posedge clk_i) begin
        if (rst_ni && w_enter_done && w_op_rw) begin
            r_mem[w_op_idx] <= w_op_wdata;
        end
    end

    assign S_DMEM_done_o = (r_state == ST_DONE);
    assign S_DMEM_data_o = r_rdata;
    assign busy_o        = (r_state != ST_IDLE);
endmodule
